// File: rtl/sa_operand_feeder3x3_if.sv
// Operand-feeder bus: buffer load port, run control and the unskewed
// row/column operand streams toward the 3x3 systolic MAC array.
interface sa_operand_feeder3x3_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic             wr_sel;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             acc_clr;
  logic [WIDTH-1:0] a_out0;
  logic [WIDTH-1:0] a_out1;
  logic [WIDTH-1:0] a_out2;
  logic [WIDTH-1:0] b_out0;
  logic [WIDTH-1:0] b_out1;
  logic [WIDTH-1:0] b_out2;
  logic             valid;
  logic             done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, acc_clr, a_out0, a_out1, a_out2,
    input  b_out0, b_out1, b_out2, valid, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, acc_clr, a_out0, a_out1, a_out2,
    output b_out0, b_out1, b_out2, valid, done
  );
endinterface

// File: rtl/sa_operand_feeder3x3.sv
// Loadable double 3x3 matrix buffer that clears the array accumulators and then
// streams A by columns and B by rows, followed by a zero-operand drain.
module sa_operand_feeder3x3 #(
  parameter int WIDTH        = 16,
  parameter int DRAIN_CYCLES = 6
) (
  input logic                    clk,
  input logic                    reset,
  sa_operand_feeder3x3_if.slave  bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_r;
  logic [1:0]       step_r;
  logic [DW-1:0]    drain_r;
  logic [WIDTH-1:0] a_buf_r [9];
  logic [WIDTH-1:0] b_buf_r [9];
  logic             busy_r, acc_clr_r, valid_r, done_r;
  logic [WIDTH-1:0] a0_r, a1_r, a2_r, b0_r, b1_r, b2_r;
  logic [1:0]       next_step_s;
  logic [WIDTH-1:0] a0_s, a1_s, a2_s, b0_s, b1_s, b2_s;
  logic             wr_ok_s;

  // Buffers only change while idle, so a run always sees a frozen matrix pair
  assign wr_ok_s = bus.wr_en && (state_r == IDLE) && (bus.wr_addr <= 4'd8);

  // Matrix buffer storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        a_buf_r[i] <= '0;
        b_buf_r[i] <= '0;
      end
    end else begin
      if (wr_ok_s) begin
        if (bus.wr_sel) begin
          b_buf_r[bus.wr_addr] <= bus.wr_data;
        end else begin
          a_buf_r[bus.wr_addr] <= bus.wr_data;
        end
      end
    end
  end

  // Operands for the stream step about to be presented: A column k, B row k
  always_comb begin
    next_step_s = 2'd0;
    if (state_r == STREAM) begin
      next_step_s = step_r + 2'd1;
    end else begin
      next_step_s = 2'd0;
    end
    a0_s = '0; a1_s = '0; a2_s = '0;
    b0_s = '0; b1_s = '0; b2_s = '0;
    case (next_step_s)
      2'd0: begin
        a0_s = a_buf_r[0]; a1_s = a_buf_r[3]; a2_s = a_buf_r[6];
        b0_s = b_buf_r[0]; b1_s = b_buf_r[1]; b2_s = b_buf_r[2];
      end
      2'd1: begin
        a0_s = a_buf_r[1]; a1_s = a_buf_r[4]; a2_s = a_buf_r[7];
        b0_s = b_buf_r[3]; b1_s = b_buf_r[4]; b2_s = b_buf_r[5];
      end
      2'd2: begin
        a0_s = a_buf_r[2]; a1_s = a_buf_r[5]; a2_s = a_buf_r[8];
        b0_s = b_buf_r[6]; b1_s = b_buf_r[7]; b2_s = b_buf_r[8];
      end
      default: begin
        a0_s = '0; a1_s = '0; a2_s = '0;
        b0_s = '0; b1_s = '0; b2_s = '0;
      end
    endcase
  end

  // Run sequencer; outputs are registered for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      step_r    <= 2'd0;
      drain_r   <= '0;
      busy_r    <= 1'b0;
      acc_clr_r <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      a0_r <= '0; a1_r <= '0; a2_r <= '0;
      b0_r <= '0; b1_r <= '0; b2_r <= '0;
    end else begin
      acc_clr_r <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      a0_r <= '0; a1_r <= '0; a2_r <= '0;
      b0_r <= '0; b1_r <= '0; b2_r <= '0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r   <= CLR;
            busy_r    <= 1'b1;
            acc_clr_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CLR: begin
          state_r <= STREAM;
          step_r  <= 2'd0;
          busy_r  <= 1'b1;
          valid_r <= 1'b1;
          a0_r <= a0_s; a1_r <= a1_s; a2_r <= a2_s;
          b0_r <= b0_s; b1_r <= b1_s; b2_r <= b2_s;
        end
        STREAM: begin
          busy_r <= 1'b1;
          if (step_r >= 2'd2) begin
            step_r  <= 2'd0;
            drain_r <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            step_r  <= step_r + 2'd1;
            valid_r <= 1'b1;
            a0_r <= a0_s; a1_r <= a1_s; a2_r <= a2_s;
            b0_r <= b0_s; b1_r <= b1_s; b2_r <= b2_s;
          end
        end
        DRAIN: begin
          busy_r <= 1'b1;
          if (drain_r >= DRAIN_LAST) begin
            state_r <= DONE;
            drain_r <= '0;
            done_r  <= 1'b1;
          end else begin
            drain_r <= drain_r + DW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          step_r  <= 2'd0;
          drain_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.acc_clr = acc_clr_r;
  assign bus.valid   = valid_r;
  assign bus.done    = done_r;
  assign bus.a_out0  = a0_r;
  assign bus.a_out1  = a1_r;
  assign bus.a_out2  = a2_r;
  assign bus.b_out0  = b0_r;
  assign bus.b_out1  = b1_r;
  assign bus.b_out2  = b2_r;
endmodule

// File: tb/tb_sa_operand_feeder3x3.sv
// Bench for sa_operand_feeder3x3: cycle-indexed scoreboard of every output,
// load table, corner-case sequences and a behavioural array accumulation.
module tb_sa_operand_feeder3x3;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sa_operand_feeder3x3_if #(.WIDTH(16)) f ();
  sa_operand_feeder3x3 #(.WIDTH(16), .DRAIN_CYCLES(6)) dut (.clk(clk), .reset(reset), .bus(f));

  typedef struct packed {
    logic busy; logic acc_clr; logic valid; logic done;
    logic [15:0] a0; logic [15:0] a1; logic [15:0] a2;
    logic [15:0] b0; logic [15:0] b1; logic [15:0] b2;
  } out_t;

  typedef struct {
    logic we; logic sel; logic [3:0] addr; logic [15:0] data; logic st;
    logic exp_busy; logic exp_valid;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ma [9];
  logic [15:0] mb [9];
  logic [15:0] a_def [9];
  logic [15:0] b_def [9];
  int          m_cnt = 0;
  out_t        sb_q [$];
  longint      acc [3][3];
  int          done_count = 0;
  int          cyc = 0;
  int          last_done = -1;
  int          gaps [$];
  logic [15:0] cap_a0, cap_b1;
  vec_t        vecs [21];

  // Expected outputs for run cycle m_cnt (0 idle, 1 clear, 2..4 stream, 5..10 drain, 11 done)
  function automatic out_t model_out();
    out_t o;
    int k;
    o = '0;
    if (m_cnt > 0) o.busy = 1'b1;
    if (m_cnt == 1) o.acc_clr = 1'b1;
    if (m_cnt >= 2 && m_cnt <= 4) begin
      k = m_cnt - 2;
      o.valid = 1'b1;
      o.a0 = ma[k];     o.a1 = ma[3 + k];     o.a2 = ma[6 + k];
      o.b0 = mb[3 * k]; o.b1 = mb[3 * k + 1]; o.b2 = mb[3 * k + 2];
    end
    if (m_cnt == 11) o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.busy = f.busy; o.acc_clr = f.acc_clr; o.valid = f.valid; o.done = f.done;
    o.a0 = f.a_out0; o.a1 = f.a_out1; o.a2 = f.a_out2;
    o.b0 = f.b_out0; o.b1 = f.b_out1; o.b2 = f.b_out2;
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("busy=%b clr=%b valid=%b done=%b a=%0d/%0d/%0d b=%0d/%0d/%0d",
                     o.busy, o.acc_clr, o.valid, o.done, o.a0, o.a1, o.a2, o.b0, o.b1, o.b2);
  endfunction

  task automatic report(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_val(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at next negedge
  task automatic cycle(input logic we, input logic sel, input logic [3:0] addr,
                       input logic [15:0] data, input logic st);
    out_t got;
    int   idx;
    logic [15:0] av [3];
    logic [15:0] bv [3];
    f.wr_en = we; f.wr_sel = sel; f.wr_addr = addr; f.wr_data = data; f.start = st;
    @(posedge clk);
    idx = int'(addr);
    if (m_cnt == 0) begin
      if (we && idx <= 8) begin
        if (sel) mb[idx] = data;
        else     ma[idx] = data;
      end
      if (st) m_cnt = 1;
    end else if (m_cnt == 11) begin
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    sb_q.push_back(model_out());
    @(negedge clk);
    cyc++;
    got = sample();
    report($sformatf("out_cycle%0d", cyc), got, sb_q.pop_front());
    av[0] = got.a0; av[1] = got.a1; av[2] = got.a2;
    bv[0] = got.b0; bv[1] = got.b1; bv[2] = got.b2;
    if (got.acc_clr) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) acc[i][j] = 0;
    end
    if (got.valid) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc[i][j] += longint'($signed(av[i])) * longint'($signed(bv[j]));
    end
    if (got.valid && m_cnt == 2) cap_a0 = got.a0;
    if (got.valid && m_cnt == 3) cap_b1 = got.b1;
    if (got.done) begin
      done_count++;
      if (last_done >= 0) gaps.push_back(cyc - last_done);
      last_done = cyc;
    end
  endtask

  // Called at a negedge: reset asserted mid-cycle, outputs must clear before the next edge
  task automatic async_reset_check(input string name);
    out_t z;
    z = '0;
    #2;
    reset = 1'b1;
    #1;
    report(name, sample(), z);
    m_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      ma[i] = 16'd0;
      mb[i] = 16'd0;
    end
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    longint exp_c;
    int     dc;
    f.wr_en = 1'b0; f.wr_sel = 1'b0; f.wr_addr = 4'd0; f.wr_data = 16'd0; f.start = 1'b0;
    a_def = '{16'd2048, 16'd1024, 16'd2048, 16'd3072, 16'd2048, 16'd1024, 16'd1024, 16'd3072, 16'd1024};
    b_def = '{16'd1024, 16'd4096, 16'd1024, 16'd2048, 16'd1024, 16'd3072, 16'd4096, 16'd2048, 16'd4096};
    for (int i = 0; i < 9; i++) begin
      ma[i] = 16'd0;
      mb[i] = 16'd0;
    end

    async_reset_check("reset_async");

    // Load table: two idle cycles, A, B, then an out-of-range address write
    vecs[0] = '{1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      vecs[2 + i]  = '{1'b1, 1'b0, 4'(i), a_def[i], 1'b0, 1'b0, 1'b0};
      vecs[11 + i] = '{1'b1, 1'b1, 4'(i), b_def[i], 1'b0, 1'b0, 1'b0};
    end
    vecs[20] = '{1'b1, 1'b0, 4'd12, 16'h1111, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].st);
      check_val($sformatf("load_vec%0d_busy_valid", i), longint'({f.busy, f.valid}),
                longint'({vecs[i].exp_busy, vecs[i].exp_valid}));
    end

    // Run 1 with a write attempt to A[0] during STREAM
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    for (int t = 0; t < 11; t++) begin
      cycle((m_cnt >= 2 && m_cnt <= 3), 1'b0, 4'd0, 16'd7777, 1'b0);
    end
    check_val("run1_done_count", done_count, 1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        exp_c = 0;
        for (int k = 0; k < 3; k++)
          exp_c += longint'(a_def[3 * i + k]) * longint'(b_def[3 * k + j]);
        check_val($sformatf("pe_%0d_%0d", i, j), acc[i][j] >>> 10, exp_c >>> 10);
      end
    end

    // Run 2: start together with B[4]=5120, second start during DRAIN
    cycle(1'b1, 1'b1, 4'd4, 16'd5120, 1'b1);
    for (int t = 0; t < 12; t++) begin
      cycle(1'b0, 1'b0, 4'd0, 16'd0, (m_cnt == 6));
    end
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    check_val("run2_a0_step0", cap_a0, 2048);
    check_val("run2_b1_step1", cap_b1, 5120);
    check_val("run2_done_count", done_count, 2);

    // Back-to-back runs with start held high
    gaps.delete();
    last_done = -1;
    for (int t = 0; t < 30; t++) cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    for (int t = 0; t < 12 && m_cnt != 0; t++) cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    check_val("b2b_gap_count", gaps.size(), 2);
    foreach (gaps[g]) check_val($sformatf("b2b_gap%0d", g), gaps[g], 12);

    // Reset at STREAM step 1, then a run over the cleared buffers
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    for (int t = 0; t < 5 && m_cnt != 3; t++) cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    dc = done_count;
    async_reset_check("reset_midrun");
    for (int t = 0; t < 14; t++) cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    check_val("no_done_after_reset", done_count, dc);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    for (int t = 0; t < 12; t++) cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    check_val("post_reset_done_count", done_count, dc + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
